tx_frame_reader: RTL and testbench

- Read-side engine for the Ethernet transmit frame buffer, a 2048 x 9 dual-port RAM.
- The writer fills port A with 9-bit words: bits [7:0] carry a byte, bit [8] marks the last byte of a frame.
- This block drains port B and presents bytes on a valid/ready stream to the MAC transmit path.
- It returns its consumed pointer so the writer can compute free space.

---
 rtl/txr_pkg.sv | 17 +
 rtl/txr_out_fifo.sv | 44 ++++
 rtl/tx_frame_reader.sv | 89 ++++++++
 tb/tb_tx_frame_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/txr_pkg.sv
// Shared constants, pointer type and pointer arithmetic for the TX frame buffer reader.
// Pointers carry one extra wrap bit above the RAM address so full and empty can be told apart.
package txr_pkg;

   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 9;
   localparam int LAST_BIT   = DATA_W - 1;
   localparam int IFG_CYCLES = 12;

   typedef logic [ADDR_W:0] ptr_t;

   // The natural binary carry into the MSB implements the 2047 -> 0 wrap with wrap-bit toggle.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return p + ptr_t'(1);
   endfunction

endpackage

// File: rtl/txr_out_fifo.sv
// Two-entry output buffer for 9-bit RAM words; head is the oldest registered entry.
// Write lands in the cycle after push; caller guarantees no push into a full buffer without a pop.
module txr_out_fifo
   import txr_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [1:0]        count
);

   logic [DATA_W-1:0] mem [2];
   logic              wr_idx;
   logic              rd_idx;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_idx <= 1'b0;
         rd_idx <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_idx] <= push_data;
            wr_idx      <= ~wr_idx;
         end
         if (pop) begin
            rd_idx <= ~rd_idx;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_idx];

endmodule

// File: rtl/tx_frame_reader.sv
// Drains the TX frame RAM (port B) into a byte stream; first byte 2 cycles after commit, 1 byte/cycle sustained.
// tx_ready low holds tx_data/tx_last and throttles fetching; TXR_IFG_EN adds an idle gap after each frame.
module tx_frame_reader
   import txr_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W:0]   commit_ptr,
   output logic [ADDR_W:0]   rd_ptr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_ce,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   output logic              tx_last,
   input  logic              tx_ready,
   output logic              busy,
   output logic              frame_done
);

   ptr_t              fetch_ptr;
   logic              ce_d;
   logic [1:0]        occ;
   logic [DATA_W-1:0] head;
   logic              avail;
   logic              accept;
   logic              in_gap;
   logic [2:0]        pending;

   assign avail   = (fetch_ptr != commit_ptr);
   assign accept  = tx_valid & tx_ready;
   assign pending = {1'b0, occ} + {2'b00, ce_d};

   // A pop this cycle frees a slot, which is what lets a 2-entry buffer sustain full rate.
   assign ram_ce   = avail && (pending < (3'd2 + {2'b00, accept}));
   assign ram_addr = fetch_ptr[ADDR_W-1:0];

   assign tx_data    = head[7:0];
   assign tx_last    = head[LAST_BIT];
   assign tx_valid   = (occ != 2'd0) && !in_gap;
   assign frame_done = accept & tx_last;

   txr_out_fifo u_out_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (ce_d),
      .push_data (ram_dout),
      .pop       (accept),
      .head      (head),
      .count     (occ)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_ptr <= '0;
         ce_d      <= 1'b0;
         rd_ptr    <= '0;
         busy      <= 1'b0;
      end else begin
         ce_d <= ram_ce;
         if (ram_ce) begin
            fetch_ptr <= ptr_inc(fetch_ptr);
         end
         if (accept) begin
            rd_ptr <= ptr_inc(rd_ptr);
            busy   <= !tx_last;
         end
      end
   end

`ifdef TXR_IFG_EN
   logic [7:0] ifg_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ifg_cnt <= 8'd0;
      end else if (accept && tx_last) begin
         ifg_cnt <= 8'(IFG_CYCLES);
      end else if (ifg_cnt != 8'd0) begin
         ifg_cnt <= ifg_cnt - 8'd1;
      end
   end

   assign in_gap = (ifg_cnt != 8'd0);
`else
   assign in_gap = 1'b0;
`endif

endmodule

// File: tb/tb_tx_frame_reader.sv
// Directed bench for tx_frame_reader with a RAM model and a queue-based byte scoreboard.
module tb_tx_frame_reader;
   import txr_pkg::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic [11:0] commit_ptr;
   logic [11:0] rd_ptr;
   logic [10:0] ram_addr;
   logic        ram_ce;
   logic [8:0]  ram_dout = 9'd0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_last;
   logic        tx_ready;
   logic        busy;
   logic        frame_done;

   always #5 clk = ~clk;

   tx_frame_reader dut (
      .clk        (clk),
      .rstn       (rstn),
      .commit_ptr (commit_ptr),
      .rd_ptr     (rd_ptr),
      .ram_addr   (ram_addr),
      .ram_ce     (ram_ce),
      .ram_dout   (ram_dout),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_last    (tx_last),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   logic [8:0] ram [2048];
   always @(posedge clk) if (ram_ce) ram_dout <= ram[ram_addr];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Model: every committed word becomes one expected byte, in order.
   logic [8:0]  expq [$];
   logic [10:0] ce_log [$];
   int          acc_log [$];
   logic [11:0] exp_rd, exp_fetch;
   logic        busy_m, stalled, chk_en, acc;
   logic [8:0]  stall_w, hw;
   int          issued, acc_cnt, fd_cnt, cyc;
   logic [3:0]  pat = 4'b1001;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic clear_model();
      expq.delete();
      exp_rd = 12'd0; exp_fetch = 12'd0; busy_m = 1'b0; stalled = 1'b0;
      issued = 0; acc_cnt = 0;
   endtask

   always @(negedge clk) begin
      if (rstn && chk_en) begin
         acc = tx_valid && tx_ready;
         if (ram_ce) begin
            check("ce_addr", 32'(ram_addr), 32'(exp_fetch[10:0]));
            check("ce_avail", 32'(exp_fetch != commit_ptr), 32'd1);
            check("ce_room", 32'((issued + 1 - acc_cnt - (acc ? 1 : 0)) <= 2), 32'd1);
            ce_log.push_back(ram_addr);
            exp_fetch = exp_fetch + 12'd1;
            issued++;
         end
         check("rd_ptr", 32'(rd_ptr), 32'(exp_rd));
         check("busy", 32'(busy), 32'(busy_m));
         hw = (expq.size() != 0) ? expq[0] : 9'h0;
         if (tx_valid) begin
            check("valid_has_data", 32'(expq.size() != 0), 32'd1);
            check("tx_data", 32'(tx_data), 32'(hw[7:0]));
            check("tx_last", 32'(tx_last), 32'(hw[8]));
         end
         if (stalled) check("stall_hold", 32'({tx_valid, tx_last, tx_data}), 32'({1'b1, stall_w}));
         check("frame_done", 32'(frame_done), 32'(acc && hw[8]));
         if (acc && expq.size() != 0) begin
            void'(expq.pop_front());
            exp_rd = exp_rd + 12'd1;
            busy_m = !hw[8];
            acc_cnt++;
            acc_log.push_back(cyc);
         end
         if (frame_done) fd_cnt++;
         stalled = tx_valid && !tx_ready;
         stall_w = {tx_last, tx_data};
      end
   end

   task automatic do_commit(input logic [11:0] np);
      for (logic [11:0] p = commit_ptr; p != np; p = p + 12'd1) expq.push_back(ram[p[10:0]]);
      commit_ptr = np;
   endtask

   task automatic drain(input string name, input bit toggle, input int limit);
      int i;
      for (i = 0; i < limit && (expq.size() != 0); i++) begin
         @(posedge clk); #1;
         if (toggle) tx_ready = pat[i % 4];
      end
      check(name, 32'(expq.size()), 32'd0);
      tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_rd_ptr"}, 32'(rd_ptr), 32'd0);
      check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      check({tag, "_ram_ce"}, 32'(ram_ce), 32'd0);
      check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      check({tag, "_tx_last"}, 32'(tx_last), 32'd0);
      check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int start;
      cyc = 0; fd_cnt = 0; chk_en = 1'b0;
      rstn = 1'b0; commit_ptr = 12'd0; tx_ready = 1'b0;
      clear_model();
      ram[0] = 9'h041; ram[1] = 9'h042; ram[2] = 9'h043; ram[3] = 9'h044; ram[4] = 9'h145;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;
      rstn = 1'b1; chk_en = 1'b1;

      // Single 5-byte frame at full rate
      tx_ready = 1'b1;
      @(posedge clk); #1;
      acc_log.delete();
      do_commit(12'd5);
      @(negedge clk);
      check("lat_c0_valid", 32'(tx_valid), 32'd0);
      check("lat_c0_ce", 32'(ram_ce), 32'd1);
      @(negedge clk);
      check("lat_c1_valid", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check("lat_c2_valid", 32'(tx_valid), 32'd1);
      check("lat_c2_data", 32'(tx_data), 32'h41);
      drain("drain_f1", 1'b0, 50);
      check("f1_rd_ptr", 32'(rd_ptr), 32'd5);
      check("f1_frame_done", 32'(fd_cnt), 32'd1);
      check("f1_accepts", 32'(acc_log.size()), 32'd5);
      if (acc_log.size() == 5) check("f1_back_to_back", 32'(acc_log[4] - acc_log[0]), 32'd4);

      // Same frame with a stalling MAC
      for (int i = 0; i < 5; i++) ram[5 + i] = ram[i];
      do_commit(12'd10);
      drain("drain_f2", 1'b1, 100);
      check("f2_rd_ptr", 32'(rd_ptr), 32'd10);
      check("f2_frame_done", 32'(fd_cnt), 32'd2);

      // Two frames (3 + 1 bytes) committed together
      ram[10] = 9'h051; ram[11] = 9'h052; ram[12] = 9'h153; ram[13] = 9'h154;
      acc_log.delete();
      do_commit(12'd14);
      drain("drain_f3", 1'b0, 100);
      check("f3_accepts", 32'(acc_log.size()), 32'd4);
      if (acc_log.size() == 4) begin
         check("f3_first_frame", 32'(acc_log[2] - acc_log[0]), 32'd2);
`ifdef TXR_IFG_EN
         check("f3_ifg_gap", 32'(acc_log[3] - acc_log[2]), 32'd13);
`else
         check("f3_no_gap", 32'(acc_log[3] - acc_log[2]), 32'd1);
`endif
      end
      check("f3_frame_done", 32'(fd_cnt), 32'd4);
      check("f3_busy", 32'(busy), 32'd0);

      // Empty: nothing committed beyond rd_ptr
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         check("empty_ce", 32'(ram_ce), 32'd0);
         check("empty_valid", 32'(tx_valid), 32'd0);
      end

      // Advance to 0x7FE, then a frame crossing the wrap
      for (int i = 14; i < 12'h7FE; i++) ram[i] = {1'b0, 8'(i)};
      ram[12'h7FD] = 9'h1AA;
      do_commit(12'h7FE);
      drain("drain_prefill", 1'b0, 3000);
      check("prefill_rd_ptr", 32'(rd_ptr), 32'h7FE);
      ram[12'h7FE] = 9'h061; ram[12'h7FF] = 9'h062; ram[0] = 9'h063; ram[1] = 9'h164;
      ce_log.delete();
      do_commit(12'h802);
      drain("drain_wrap", 1'b0, 100);
      check("wrap_ce_count", 32'(ce_log.size()), 32'd4);
      if (ce_log.size() == 4) begin
         check("wrap_addr0", 32'(ce_log[0]), 32'h7FE);
         check("wrap_addr1", 32'(ce_log[1]), 32'h7FF);
         check("wrap_addr2", 32'(ce_log[2]), 32'h000);
         check("wrap_addr3", 32'(ce_log[3]), 32'h001);
      end
      check("wrap_rd_ptr", 32'(rd_ptr), 32'h802);

      // Reset mid-frame after two of five bytes
      ram[2] = 9'h071; ram[3] = 9'h072; ram[4] = 9'h073; ram[5] = 9'h074; ram[6] = 9'h175;
      start = acc_cnt;
      do_commit(12'h807);
      for (int i = 0; i < 60 && (acc_cnt - start) < 2; i++) begin
         @(posedge clk); #1;
      end
      tx_ready = 1'b0;
      check("mid_two_accepted", 32'(acc_cnt - start), 32'd2);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd1);
      check("mid_valid_held", 32'(tx_valid), 32'd1);
      #2;
      chk_en = 1'b0; rstn = 1'b0; commit_ptr = 12'd0;
      #1;
      check_reset_vals("async");
      clear_model();
      @(posedge clk); #1;
      rstn = 1'b1; chk_en = 1'b1; tx_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("post_reset_ce", 32'(ram_ce), 32'd0);
         check("post_reset_valid", 32'(tx_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
